stoch_grad_sparsifier: RTL and testbench
========================================

STOCH_GRAD_SPARSIFIER -- requirements
Module: stoch_grad_sparsifier

Interface
REQ-001 SHALL have parameter W_SIZE, default 1024, meaning flip-vector width in bits.
REQ-002 SHALL have parameter CHUNK, default 64, meaning bits processed per cycle; W_SIZE % CHUNK == 0.
REQ-003 SHALL have parameter PROB_BITS, default 8, meaning resolution of keep-probability threshold.
REQ-004 SHALL have parameter SEED, default 16'hACE1, meaning base LFSR seed.
REQ-005 SHALL use one clock and a synchronous, active-high reset, with ports:
- clk_in  input  1  system clock
- rst_in  input  1  synchronous active-high reset
- flip_weight_in  input  W_SIZE  raw per-weight flip requests
- valid_in  input  1  request valid
- ready_out  output  1  block idle, accepts request
- threshold_in  input  PROB_BITS  keep probability = threshold/2^PROB_BITS
- max_flips_in  input  $clog2(W_SIZE+1)  cap on surviving flips
- flip_weight_out  output  W_SIZE  sparsified flip vector
- flip_count_out  output  $clog2(W_SIZE+1)  popcount of flip_weight_out
- valid_out  output  1  result valid
- ready_in  input  1  downstream accepts result

Function
REQ-006 SHALL implement FSM IDLE -> SCAN -> DONE -> IDLE.
REQ-007 IDLE: ready_out=1; on valid_in&&ready_out, SHALL latch flip_weight_in, threshold_in, max_flips_in, clear count, chunk index=0, go SCAN.
REQ-008 SCAN: SHALL process chunk k (bits k*CHUNK..k*CHUNK+CHUNK-1) per cycle, W_SIZE/CHUNK cycles total, then go DONE.
REQ-009 Bit i of chunk SHALL be kept iff input bit=1 AND (lane i random low PROB_BITS < threshold, or threshold == all-ones).
REQ-010 threshold==0 SHALL yield all-zero output; threshold all-ones SHALL pass input unchanged (subject to cap).
REQ-011 Random source SHALL be CHUNK 16-bit Galois LFSRs (poly x^16+x^14+x^13+x^11+1), lane i seeded SEED^i, forced to 1 if zero; each steps once per SCAN cycle only.
REQ-012 Cap: kept bits SHALL be admitted lowest index first; once count == latched max_flips, later kept bits SHALL be cleared, including within the same chunk.
REQ-013 flip_count_out SHALL equal popcount of flip_weight_out; never exceeds max_flips (cap on) or W_SIZE.
REQ-014 DONE: valid_out=1, outputs stable; on ready_in SHALL go IDLE next cycle. valid_in ignored outside IDLE.
REQ-015 Latency accept->valid_out SHALL be W_SIZE/CHUNK+1 cycles (17 at defaults).
REQ-016 LFSR state SHALL persist across requests (not reseeded per request).

Reset
REQ-017 On rst_in, SHALL go IDLE, ready_out=1, valid_out=0, flip_weight_out=0, flip_count_out=0, LFSRs reseeded per REQ-011.
REQ-018 Reset mid-SCAN or in DONE SHALL abort; no partial result emitted.

Configuration
REQ-019 Macro STOCH_GRAD_CAP_EN defined: cap per REQ-012 active.
REQ-020 STOCH_GRAD_CAP_EN undefined: max_flips_in port present but ignored, no prefix-count logic; all kept bits survive.

Structure
REQ-021 Shared package stoch_grad_pkg SHALL hold FSM state enum, LFSR width/polynomial constants, and default SEED.
REQ-022 Sub-module lfsr16 (one-lane Galois LFSR with step enable and seed) SHALL be instantiated CHUNK times.

Verification
REQ-023 Input all-ones, threshold=0 -> output 0, count 0, valid_out at cycle 17.
REQ-024 Input 0xAAAA.. pattern, threshold=8'hFF, cap=1024 -> output equals input, count 512.
REQ-025 Input all-ones, threshold=8'hFF, cap=5 (CAP_EN) -> bits 0..4 set only, count 5; CAP_EN off -> count 1024.
REQ-026 Input all-ones, threshold=8'h40, 64 requests -> mean count within 256±16; output identical to bit-accurate LFSR model.
REQ-027 rst_in at SCAN cycle 7 -> next cycle ready_out=1, valid_out=0; next request reproduces first post-reset result.
REQ-028 valid_out held with ready_in=0 for 10 cycles -> outputs stable, valid_in ignored; ready_in=1 -> IDLE next cycle.

Source files
------------

// File: rtl/stoch_grad_pkg.sv
// Shared types and constants for the stochastic gradient-flip sparsifier.
// The optional flip cap is enabled by the STOCH_GRAD_CAP_EN macro in the top module.
package stoch_grad_pkg;

    localparam int unsigned       LFSR_W       = 16;
    // Galois taps for x^16 + x^14 + x^13 + x^11 + 1 (right-shifting form)
    localparam logic [LFSR_W-1:0] LFSR_POLY    = 16'hB400;
    localparam logic [LFSR_W-1:0] DEFAULT_SEED = 16'hACE1;

    typedef enum logic [1:0] {
        StIdle,
        StScan,
        StDone
    } state_e;

    // An all-zero Galois LFSR never leaves zero, so substitute 1.
    function automatic logic [LFSR_W-1:0] nonzero_seed(input logic [LFSR_W-1:0] s);
        return (s == '0) ? {{(LFSR_W-1){1'b0}}, 1'b1} : s;
    endfunction

endpackage

// File: rtl/lfsr16.sv
// One-lane 16-bit Galois LFSR with step enable; exposes the low OUT_W state bits.
// Reseeds synchronously on reset.
module lfsr16
    import stoch_grad_pkg::*;
#(
    parameter logic [LFSR_W-1:0] SEED  = DEFAULT_SEED,
    parameter int unsigned       OUT_W = LFSR_W
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             step_in,
    output logic [OUT_W-1:0] rand_out
);

    localparam logic [LFSR_W-1:0] SEED_NZ = nonzero_seed(SEED);

    logic [LFSR_W-1:0] state_q, state_d;

    always_comb begin
        state_d = state_q;
        if (step_in) begin
            state_d = state_q >> 1;
            if (state_q[0]) begin
                state_d = state_d ^ LFSR_POLY;
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q <= SEED_NZ;
        end else begin
            state_q <= state_d;
        end
    end

    assign rand_out = state_q[OUT_W-1:0];

endmodule

// File: rtl/stoch_grad_sparsifier.sv
// Stochastically thins a flip-request vector, CHUNK bits per cycle, using per-lane LFSRs.
// Define STOCH_GRAD_CAP_EN to cap surviving flips at max_flips_in (lowest index first).
module stoch_grad_sparsifier
    import stoch_grad_pkg::*;
#(
    parameter int unsigned       W_SIZE    = 1024,
    parameter int unsigned       CHUNK     = 64,
    parameter int unsigned       PROB_BITS = 8,
    parameter logic [LFSR_W-1:0] SEED      = DEFAULT_SEED
) (
    input  logic                         clk_in,
    input  logic                         rst_in,
    input  logic [W_SIZE-1:0]            flip_weight_in,
    input  logic                         valid_in,
    output logic                         ready_out,
    input  logic [PROB_BITS-1:0]         threshold_in,
    input  logic [$clog2(W_SIZE+1)-1:0]  max_flips_in,
    output logic [W_SIZE-1:0]            flip_weight_out,
    output logic [$clog2(W_SIZE+1)-1:0]  flip_count_out,
    output logic                         valid_out,
    input  logic                         ready_in
);

    localparam int unsigned CNT_W    = $clog2(W_SIZE + 1);
    localparam int unsigned N_CHUNKS = W_SIZE / CHUNK;
    localparam int unsigned IDX_W    = (N_CHUNKS > 1) ? $clog2(N_CHUNKS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_CHUNKS - 1);

    state_e                 state_q, state_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic [W_SIZE-1:0]      data_q, data_d;
    logic [PROB_BITS-1:0]   thr_q, thr_d;
    logic [W_SIZE-1:0]      out_q, out_d;
    logic [CNT_W-1:0]       count_q, count_d;

    logic                   lfsr_step;
    logic [31:0]            chunk_base;
    logic [CHUNK-1:0]       chunk_in;
    logic [CHUNK-1:0]       chunk_kept;
    logic [CHUNK-1:0]       chunk_res;
    logic [CNT_W-1:0]       run_cnt;
    logic [PROB_BITS-1:0]   lane_rand [CHUNK];

    for (genvar g = 0; g < CHUNK; g++) begin : g_lane
        lfsr16 #(
            .SEED  (SEED ^ LFSR_W'(g)),
            .OUT_W (PROB_BITS)
        ) u_lfsr (
            .clk_in   (clk_in),
            .rst_in   (rst_in),
            .step_in  (lfsr_step),
            .rand_out (lane_rand[g])
        );
    end

    assign chunk_base = 32'(idx_q) * CHUNK;

    always_comb begin
        chunk_in = data_q[chunk_base +: CHUNK];
        for (int unsigned i = 0; i < CHUNK; i++) begin
            chunk_kept[i] = chunk_in[i] && ((&thr_q) || (lane_rand[i] < thr_q));
        end
    end

`ifdef STOCH_GRAD_CAP_EN
    logic [CNT_W-1:0] max_q, max_d;

    // Serial admission so that bits within one chunk respect the cap in index order.
    always_comb begin
        run_cnt   = count_q;
        chunk_res = '0;
        for (int unsigned i = 0; i < CHUNK; i++) begin
            if (chunk_kept[i] && (run_cnt < max_q)) begin
                chunk_res[i] = 1'b1;
                run_cnt      = run_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

    always_comb begin
        max_d = max_q;
        if (state_q == StIdle && valid_in) begin
            max_d = max_flips_in;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            max_q <= '0;
        end else begin
            max_q <= max_d;
        end
    end
`else
    logic unused_max_flips;
    assign unused_max_flips = ^max_flips_in;

    always_comb begin
        run_cnt   = count_q;
        chunk_res = chunk_kept;
        for (int unsigned i = 0; i < CHUNK; i++) begin
            run_cnt = run_cnt + {{(CNT_W-1){1'b0}}, chunk_kept[i]};
        end
    end
`endif

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        data_d    = data_q;
        thr_d     = thr_q;
        out_d     = out_q;
        count_d   = count_q;
        lfsr_step = 1'b0;
        ready_out = 1'b0;
        valid_out = 1'b0;
        unique case (state_q)
            StIdle: begin
                ready_out = 1'b1;
                if (valid_in) begin
                    data_d  = flip_weight_in;
                    thr_d   = threshold_in;
                    out_d   = '0;
                    count_d = '0;
                    idx_d   = '0;
                    state_d = StScan;
                end
            end
            StScan: begin
                lfsr_step                     = 1'b1;
                out_d[chunk_base +: CHUNK]    = chunk_res;
                count_d                       = run_cnt;
                if (idx_q == LAST_IDX) begin
                    state_d = StDone;
                end else begin
                    idx_d = idx_q + {{(IDX_W-1){1'b0}}, 1'b1};
                end
            end
            StDone: begin
                valid_out = 1'b1;
                if (ready_in) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q <= StIdle;
            idx_q   <= '0;
            data_q  <= '0;
            thr_q   <= '0;
            out_q   <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            data_q  <= data_d;
            thr_q   <= thr_d;
            out_q   <= out_d;
            count_q <= count_d;
        end
    end

    assign flip_weight_out = out_q;
    assign flip_count_out  = count_q;

endmodule

// File: tb/tb_stoch_grad_sparsifier.sv
// Directed bench for stoch_grad_sparsifier with an LFSR reference model and result scoreboard.
// Expectations follow STOCH_GRAD_CAP_EN when the bench is built with it.
module tb_stoch_grad_sparsifier;

    localparam int W   = 1024;
    localparam int C   = 64;
    localparam int CW  = 11;
    localparam int NCH = W / C;

    logic          clk = 1'b0;
    logic          rst;
    logic [W-1:0]  flip_in;
    logic          valid_in;
    logic          ready_out;
    logic [7:0]    thr;
    logic [CW-1:0] maxf;
    logic [W-1:0]  flip_out;
    logic [CW-1:0] cnt_out;
    logic          valid_out;
    logic          ready_in;

    always #5 clk = ~clk;

    stoch_grad_sparsifier dut (
        .clk_in          (clk),
        .rst_in          (rst),
        .flip_weight_in  (flip_in),
        .valid_in        (valid_in),
        .ready_out       (ready_out),
        .threshold_in    (thr),
        .max_flips_in    (maxf),
        .flip_weight_out (flip_out),
        .flip_count_out  (cnt_out),
        .valid_out       (valid_out),
        .ready_in        (ready_in)
    );

    typedef struct {
        logic [W-1:0] vec;
        int           cnt;
    } exp_t;

    int           n_checks = 0;
    int           n_fail   = 0;
    logic [15:0]  m_lfsr [C];
    exp_t         sb [$];

    task automatic check_int(input string tag, input longint obs, input longint exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_vec(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        int k;
        k = 0;
        for (int j = NCH - 1; j >= 0; j--) begin
            if (obs[j*C +: C] !== exp[j*C +: C]) k = j;
        end
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s chunk %0d observed=%h expected=%h", tag, k, obs[k*C +: C],
                   exp[k*C +: C]);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < C; i++) begin
            m_lfsr[i] = 16'hACE1 ^ 16'(i);
            if (m_lfsr[i] == 16'h0) m_lfsr[i] = 16'h1;
        end
    endtask

    task automatic model_run(input logic [W-1:0] v, input logic [7:0] t, input int mx);
        exp_t e;
        logic kept;
        e.vec = '0;
        e.cnt = 0;
        for (int k = 0; k < NCH; k++) begin
            for (int i = 0; i < C; i++) begin
                kept = v[k*C + i] && ((t == 8'hFF) || (m_lfsr[i][7:0] < t));
`ifdef STOCH_GRAD_CAP_EN
                if (kept && e.cnt < mx) begin
`else
                if (kept) begin
`endif
                    e.vec[k*C + i] = 1'b1;
                    e.cnt++;
                end
            end
            for (int i = 0; i < C; i++) begin
                if (m_lfsr[i][0]) m_lfsr[i] = (m_lfsr[i] >> 1) ^ 16'hB400;
                else              m_lfsr[i] = m_lfsr[i] >> 1;
            end
        end
`ifndef STOCH_GRAD_CAP_EN
        if (mx < 0) e.cnt = -1;
`endif
        sb.push_back(e);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
    endtask

    // Returns at #1 after the accepting edge.
    task automatic send(input logic [W-1:0] v, input logic [7:0] t, input int mx);
        int n;
        n = 0;
        while (ready_out !== 1'b1 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 100) check_int("ready_wait_timeout", n, 0);
        flip_in  = v;
        thr      = t;
        maxf     = CW'(mx);
        valid_in = 1'b1;
        @(posedge clk); #1;
        valid_in = 1'b0;
        model_run(v, t, mx);
    endtask

    // Waits for valid_out; accept cycle is cycle 1, so valid_out shows up 16 edges later.
    task automatic get_result(input string tag, output logic [W-1:0] vec, output int cnt);
        int n;
        exp_t e;
        n = 0;
        while (valid_out !== 1'b1 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check_int({tag, "_latency"}, n, NCH);
        vec = flip_out;
        cnt = int'(cnt_out);
        if (sb.size() == 0) begin
            check_int({tag, "_sb_empty"}, 1, 0);
        end else begin
            e = sb.pop_front();
            check_vec({tag, "_vec"}, flip_out, e.vec);
            check_int({tag, "_cnt"}, cnt_out, e.cnt);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] ones, alt, rnd, vec, held, res_a;
        int           cnt, held_cnt, sum, cnt_a;

        ones = '1;
        for (int i = 0; i < W; i++) alt[i] = i[0];
        for (int i = 0; i < W / 32; i++) rnd[i*32 +: 32] = $urandom;

        rst      = 1'b1;
        valid_in = 1'b0;
        ready_in = 1'b1;
        flip_in  = '0;
        thr      = '0;
        maxf     = '0;
        @(posedge clk);
        do_reset();
        check_int("rst_ready", ready_out, 1);
        check_int("rst_valid", valid_out, 0);
        check_vec("rst_vec", flip_out, '0);
        check_int("rst_cnt", cnt_out, 0);

        // Threshold zero keeps nothing.
        send(ones, 8'h00, 1024);
        get_result("thr0", vec, cnt);
        check_vec("thr0_zero", vec, '0);
        check_int("thr0_cnt0", cnt, 0);
        @(posedge clk); #1;
        check_int("thr0_back_idle", ready_out, 1);

        // Threshold all-ones passes input unchanged.
        send(alt, 8'hFF, 1024);
        get_result("pass", vec, cnt);
        check_vec("pass_eq_in", vec, alt);
        check_int("pass_cnt512", cnt, 512);
        @(posedge clk); #1;

        send(ones, 8'hFF, 5);
        get_result("cap5", vec, cnt);
`ifdef STOCH_GRAD_CAP_EN
        check_vec("cap5_low5", vec, W'(32'h1F));
        check_int("cap5_cnt", cnt, 5);
`else
        check_vec("cap5_off_all", vec, ones);
        check_int("cap5_off_cnt", cnt, 1024);
`endif
        @(posedge clk); #1;

        // Quarter keep probability over many requests.
        sum = 0;
        for (int r = 0; r < 64; r++) begin
            send(ones, 8'h40, 1024);
            get_result("p25", vec, cnt);
            sum += cnt;
            @(posedge clk); #1;
        end
        check_int("p25_mean_in_range", (sum >= 240 * 64 && sum <= 272 * 64) ? 1 : 0, 1);

        // Backpressure: result must hold and new requests be ignored.
        ready_in = 1'b0;
        send(rnd, 8'h80, 1024);
        get_result("hold", held, held_cnt);
        for (int c = 0; c < 10; c++) begin
            flip_in  = ~rnd;
            thr      = 8'hFF;
            valid_in = 1'b1;
            @(posedge clk); #1;
            check_int("hold_valid", valid_out, 1);
            check_int("hold_ready_low", ready_out, 0);
            check_vec("hold_vec_stable", flip_out, held);
            check_int("hold_cnt_stable", cnt_out, held_cnt);
        end
        valid_in = 1'b0;
        ready_in = 1'b1;
        @(posedge clk); #1;
        check_int("hold_release_ready", ready_out, 1);
        check_int("hold_release_valid", valid_out, 0);
        send(rnd, 8'h80, 1024);
        get_result("after_hold", vec, cnt);
        @(posedge clk); #1;

        // Reset mid-scan aborts and reseeds the LFSRs.
        do_reset();
        send(ones, 8'h40, 1024);
        get_result("post_rst_a", res_a, cnt_a);
        @(posedge clk); #1;
        do_reset();
        send(ones, 8'h40, 1024);
        repeat (6) begin
            @(posedge clk); #1;
        end
        void'(sb.pop_back());
        do_reset();
        check_int("abort_ready", ready_out, 1);
        check_int("abort_valid", valid_out, 0);
        check_vec("abort_vec", flip_out, '0);
        check_int("abort_cnt", cnt_out, 0);
        cnt = 0;
        repeat (20) begin
            @(posedge clk); #1;
            if (valid_out === 1'b1) cnt++;
        end
        check_int("abort_no_result", cnt, 0);
        send(ones, 8'h40, 1024);
        get_result("replay", vec, cnt);
        check_vec("replay_same_vec", vec, res_a);
        check_int("replay_same_cnt", cnt, cnt_a);
        @(posedge clk); #1;

        check_int("sb_drained", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
